// File: rtl/bcd_timer_ctrl.sv
// bcd_timer_ctrl: sequencing controller for a two-digit BCD up/down counter.
// Debounced-level buttons become command pulses; a prescaler paces RUN steps.
module bcd_timer_ctrl #(
   parameter int TICK_DIV     = 4,
   parameter int ALARM_CYCLES = 8
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       BTN_START,
   input  logic       BTN_DIR,
   input  logic       BTN_CLR,
   input  logic       BTN_LOAD,
   input  logic [3:0] PRE_1,
   input  logic [3:0] PRE_0,
   input  logic [3:0] CNT_1,
   input  logic [3:0] CNT_0,
   output logic       STEP,
   output logic       DIR,
   output logic       CLR,
   output logic       LOAD,
   output logic [3:0] LD_1,
   output logic [3:0] LD_0,
   output logic       RUNNING,
   output logic       ALARM,
   output logic [1:0] STATE
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_PAUSE = 2'd2,
      S_ALARM = 2'd3
   } state_t;

   localparam int PW = $clog2(TICK_DIV);
   localparam int AW = $clog2(ALARM_CYCLES + 1);
   localparam logic [PW-1:0] PRESC_TOP = PW'(TICK_DIV - 1);
   localparam logic [AW-1:0] ALARM_TOP = AW'(ALARM_CYCLES - 1);

   state_t          state_q, state_d;
   logic [3:0]      btn_q, btn_d;
   logic            step_q, step_d;
   logic            clr_q, clr_d;
   logic            load_q, load_d;
   logic [3:0]      ld1_q, ld1_d;
   logic [3:0]      ld0_q, ld0_d;
   logic            dir_q, dir_d;
   logic            run_q, run_d;
   logic            alm_q, alm_d;
   logic [PW-1:0]   presc_q, presc_d;
   logic [AW-1:0]   acnt_q, acnt_d;

   logic [3:0]      btn_now;
   logic [3:0]      btn_edge;
   logic            at_term;
   logic            edit_ok;

   function automatic logic [3:0] clamp9(input logic [3:0] d);
      return (d > 4'd9) ? 4'd9 : d;
   endfunction

   // Bit order {clr, load, start, dir} matches command priority.
   assign btn_now  = {BTN_CLR, BTN_LOAD, BTN_START, BTN_DIR};
   assign btn_edge = btn_now & ~btn_q;
   assign at_term  = dir_q ? (CNT_1 == 4'd0 && CNT_0 == 4'd0)
                           : (CNT_1 == 4'd9 && CNT_0 == 4'd9);
   assign edit_ok  = (state_q == S_IDLE) || (state_q == S_PAUSE);

   // Command decode, run/alarm sequencing and pulse generation.
   always_comb begin
      state_d = state_q;
      btn_d   = btn_now;
      step_d  = 1'b0;
      clr_d   = 1'b0;
      load_d  = 1'b0;
      ld1_d   = ld1_q;
      ld0_d   = ld0_q;
      dir_d   = dir_q;
      presc_d = presc_q;
      acnt_d  = acnt_q;
      if (btn_edge[3]) begin
         state_d = S_IDLE;
         clr_d   = 1'b1;
         presc_d = '0;
         acnt_d  = '0;
      end else if (btn_edge[2] && edit_ok) begin
         load_d = 1'b1;
         ld1_d  = clamp9(PRE_1);
         ld0_d  = clamp9(PRE_0);
      end else if (btn_edge[1]) begin
         unique case (state_q)
            S_IDLE, S_PAUSE: begin
               state_d = S_RUN;
               presc_d = '0;
            end
            S_RUN:   state_d = S_PAUSE;
            S_ALARM: begin
               state_d = S_IDLE;
               acnt_d  = '0;
            end
            default: state_d = S_IDLE;
         endcase
      end else begin
         if (btn_edge[0] && edit_ok) dir_d = ~dir_q;
         unique case (state_q)
            S_RUN: begin
               if (at_term) begin
                  state_d = S_ALARM;
                  acnt_d  = '0;
               end else if (presc_q == PRESC_TOP) begin
                  step_d  = 1'b1;
                  presc_d = '0;
               end else begin
                  presc_d = presc_q + 1'b1;
               end
            end
            S_ALARM: begin
               if (acnt_q == ALARM_TOP) begin
                  state_d = S_IDLE;
                  acnt_d  = '0;
               end else begin
                  acnt_d = acnt_q + 1'b1;
               end
            end
            default: ;
         endcase
      end
      run_d = (state_d == S_RUN);
      alm_d = (state_d == S_ALARM);
   end

   // State and output registers; buttons reset high so held keys give no edge.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= S_IDLE;
         btn_q   <= 4'hF;
         step_q  <= 1'b0;
         clr_q   <= 1'b0;
         load_q  <= 1'b0;
         ld1_q   <= 4'd0;
         ld0_q   <= 4'd0;
         dir_q   <= 1'b0;
         run_q   <= 1'b0;
         alm_q   <= 1'b0;
         presc_q <= '0;
         acnt_q  <= '0;
      end else begin
         state_q <= state_d;
         btn_q   <= btn_d;
         step_q  <= step_d;
         clr_q   <= clr_d;
         load_q  <= load_d;
         ld1_q   <= ld1_d;
         ld0_q   <= ld0_d;
         dir_q   <= dir_d;
         run_q   <= run_d;
         alm_q   <= alm_d;
         presc_q <= presc_d;
         acnt_q  <= acnt_d;
      end
   end

   assign STEP    = step_q;
   assign DIR     = dir_q;
   assign CLR     = clr_q;
   assign LOAD    = load_q;
   assign LD_1    = ld1_q;
   assign LD_0    = ld0_q;
   assign RUNNING = run_q;
   assign ALARM   = alm_q;
   assign STATE   = state_q;

endmodule
